// File: rtl/acc_unit.sv
// acc_unit: parametrised accumulator with Z/N/C/V flags and a LIFO shadow stack.
// Optional build macro ACC_SATURATE_EN: ADD/SUB clamp to the signed range on
// overflow instead of wrapping modulo 2^DATA_WIDTH.
module acc_unit #(
  parameter int unsigned DATA_WIDTH  = 11,
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic                  clock,
  input  logic                  acc_reset,
  input  logic [DATA_WIDTH-1:0] acc_in,
  input  logic [2:0]            acc_op,
  input  logic                  acc_wr,
  output logic [DATA_WIDTH-1:0] acc_out,
  output logic                  acc_zero,
  output logic                  acc_neg,
  output logic                  acc_carry,
  output logic                  acc_ovf,
  output logic                  stack_full,
  output logic                  stack_empty,
  output logic                  acc_err
);

  localparam int unsigned MSB   = DATA_WIDTH - 1;
  localparam int unsigned SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int unsigned IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  localparam logic [2:0] OP_LOAD = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_AND  = 3'b011;
  localparam logic [2:0] OP_OR   = 3'b100;
  localparam logic [2:0] OP_XOR  = 3'b101;
  localparam logic [2:0] OP_PUSH = 3'b110;
  localparam logic [2:0] OP_POP  = 3'b111;

`ifdef ACC_SATURATE_EN
  localparam logic [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
`endif

  logic [DATA_WIDTH-1:0] r_acc;
  logic                  r_zero;
  logic                  r_neg;
  logic                  r_carry;
  logic                  r_ovf;
  logic                  r_err;
  logic [SP_W-1:0]       r_sp;
  logic [DATA_WIDTH-1:0] r_stack [STACK_DEPTH];

  logic [DATA_WIDTH:0]   w_sum;
  logic [DATA_WIDTH:0]   w_diff;
  logic                  w_add_ovf;
  logic                  w_sub_ovf;
  logic                  w_full;
  logic                  w_empty;
  logic [IDX_W-1:0]      w_push_idx;
  logic [IDX_W-1:0]      w_pop_idx;
  logic [DATA_WIDTH-1:0] w_acc_nxt;
  logic                  w_zero_nxt;
  logic                  w_neg_nxt;
  logic                  w_carry_nxt;
  logic                  w_ovf_nxt;
  logic                  w_err_nxt;
  logic [SP_W-1:0]       w_sp_nxt;
  logic                  w_push;
  logic                  w_upd_zn;

  // Widened arithmetic, overflow detection and stack pointer decode.
  always_comb begin
    w_sum      = {1'b0, r_acc} + {1'b0, acc_in};
    w_diff     = {1'b0, r_acc} - {1'b0, acc_in};
    w_add_ovf  = (r_acc[MSB] == acc_in[MSB]) && (w_sum[MSB]  != r_acc[MSB]);
    w_sub_ovf  = (r_acc[MSB] != acc_in[MSB]) && (w_diff[MSB] != r_acc[MSB]);
    w_full     = (r_sp == SP_W'(STACK_DEPTH));
    w_empty    = (r_sp == '0);
    w_push_idx = IDX_W'(r_sp);
    w_pop_idx  = IDX_W'(r_sp - SP_W'(1));
  end

  // Next-state selection for accumulator, flags, stack pointer and error.
  always_comb begin
    w_acc_nxt   = r_acc;
    w_zero_nxt  = r_zero;
    w_neg_nxt   = r_neg;
    w_carry_nxt = r_carry;
    w_ovf_nxt   = r_ovf;
    w_err_nxt   = r_err;
    w_sp_nxt    = r_sp;
    w_push      = 1'b0;
    w_upd_zn    = 1'b0;
    if (acc_wr) begin
      case (acc_op)
        OP_LOAD: begin
          w_acc_nxt   = acc_in;
          w_carry_nxt = 1'b0;
          w_ovf_nxt   = 1'b0;
          w_upd_zn    = 1'b1;
        end
        OP_ADD: begin
          w_acc_nxt   = w_sum[MSB:0];
          w_carry_nxt = w_sum[DATA_WIDTH];
          w_ovf_nxt   = w_add_ovf;
          w_upd_zn    = 1'b1;
`ifdef ACC_SATURATE_EN
          if (w_add_ovf) w_acc_nxt = r_acc[MSB] ? SAT_MIN : SAT_MAX;
`endif
        end
        OP_SUB: begin
          w_acc_nxt   = w_diff[MSB:0];
          w_carry_nxt = w_diff[DATA_WIDTH];
          w_ovf_nxt   = w_sub_ovf;
          w_upd_zn    = 1'b1;
`ifdef ACC_SATURATE_EN
          if (w_sub_ovf) w_acc_nxt = r_acc[MSB] ? SAT_MIN : SAT_MAX;
`endif
        end
        OP_AND, OP_OR, OP_XOR: begin
          if (acc_op == OP_AND)     w_acc_nxt = r_acc & acc_in;
          else if (acc_op == OP_OR) w_acc_nxt = r_acc | acc_in;
          else                      w_acc_nxt = r_acc ^ acc_in;
          w_carry_nxt = 1'b0;
          w_ovf_nxt   = 1'b0;
          w_upd_zn    = 1'b1;
        end
        OP_PUSH: begin
          if (w_full) begin
            w_err_nxt = 1'b1;
          end else begin
            w_push   = 1'b1;
            w_sp_nxt = r_sp + SP_W'(1);
          end
        end
        default: begin
          // POP: an empty stack leaves everything but the error flag alone
          if (w_empty) begin
            w_err_nxt = 1'b1;
          end else begin
            w_acc_nxt   = r_stack[w_pop_idx];
            w_sp_nxt    = r_sp - SP_W'(1);
            w_carry_nxt = 1'b0;
            w_ovf_nxt   = 1'b0;
            w_upd_zn    = 1'b1;
          end
        end
      endcase
      if (w_upd_zn) begin
        w_zero_nxt = (w_acc_nxt == '0);
        w_neg_nxt  = w_acc_nxt[MSB];
      end
    end
  end

  // Accumulator, flag, pointer and error registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (acc_reset) begin
      r_acc   <= '0;
      r_zero  <= 1'b1;
      r_neg   <= 1'b0;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
      r_err   <= 1'b0;
      r_sp    <= '0;
    end else begin
      r_acc   <= w_acc_nxt;
      r_zero  <= w_zero_nxt;
      r_neg   <= w_neg_nxt;
      r_carry <= w_carry_nxt;
      r_ovf   <= w_ovf_nxt;
      r_err   <= w_err_nxt;
      r_sp    <= w_sp_nxt;
    end
  end

  // Shadow stack storage; contents need no reset since sp gates every read.
  always_ff @(posedge clock) begin
    if (!acc_reset && w_push) r_stack[w_push_idx] <= r_acc;
  end

  assign acc_out     = r_acc;
  assign acc_zero    = r_zero;
  assign acc_neg     = r_neg;
  assign acc_carry   = r_carry;
  assign acc_ovf     = r_ovf;
  assign acc_err     = r_err;
  assign stack_full  = w_full;
  assign stack_empty = w_empty;

endmodule

// File: tb/tb_acc_unit.sv
// tb_acc_unit: directed vector bench for acc_unit (DATA_WIDTH=11, STACK_DEPTH=4).
// Honours ACC_SATURATE_EN so the same bench covers both builds.
module tb_acc_unit;

  localparam int unsigned W = 11;

  localparam logic [2:0] LD  = 3'b000;
  localparam logic [2:0] ADD = 3'b001;
  localparam logic [2:0] SUB = 3'b010;
  localparam logic [2:0] AND = 3'b011;
  localparam logic [2:0] OR  = 3'b100;
  localparam logic [2:0] XOR = 3'b101;
  localparam logic [2:0] PSH = 3'b110;
  localparam logic [2:0] POP = 3'b111;

  typedef struct {
    logic         rst;
    logic         wr;
    logic [2:0]   op;
    logic [W-1:0] din;
    logic [W-1:0] e_out;
    logic [6:0]   e_flags;   // {z, n, c, v, full, empty, err}
    string        name;
  } vec_t;

  logic         clock = 1'b0;
  logic         acc_reset;
  logic [W-1:0] acc_in;
  logic [2:0]   acc_op;
  logic         acc_wr;
  logic [W-1:0] acc_out;
  logic         acc_zero, acc_neg, acc_carry, acc_ovf;
  logic         stack_full, stack_empty, acc_err;

  int applied = 0;
  int miscompares = 0;
  vec_t vecs[$];

  acc_unit #(.DATA_WIDTH(W), .STACK_DEPTH(4)) dut (
    .clock      (clock),
    .acc_reset  (acc_reset),
    .acc_in     (acc_in),
    .acc_op     (acc_op),
    .acc_wr     (acc_wr),
    .acc_out    (acc_out),
    .acc_zero   (acc_zero),
    .acc_neg    (acc_neg),
    .acc_carry  (acc_carry),
    .acc_ovf    (acc_ovf),
    .stack_full (stack_full),
    .stack_empty(stack_empty),
    .acc_err    (acc_err)
  );

  always #5 clock = ~clock;

  // Queue one vector for the table loop.
  task automatic add(input logic rst, input logic wr, input logic [2:0] op,
                     input logic [W-1:0] din, input logic [W-1:0] eo,
                     input logic [6:0] ef, input string nm);
    vec_t v;
    v.rst = rst; v.wr = wr; v.op = op; v.din = din;
    v.e_out = eo; v.e_flags = ef; v.name = nm;
    vecs.push_back(v);
  endtask

  // Drive one cycle, let the edge happen, then compare 1 time unit later.
  task automatic step(input logic rst, input logic wr, input logic [2:0] op,
                      input logic [W-1:0] din, input logic [W-1:0] eo,
                      input logic [6:0] ef, input string nm);
    logic [6:0] got;
    acc_reset = rst; acc_wr = wr; acc_op = op; acc_in = din;
    @(posedge clock);
    #1;
    got = {acc_zero, acc_neg, acc_carry, acc_ovf, stack_full, stack_empty, acc_err};
    applied++;
    if (acc_out !== eo || got !== ef) begin
      miscompares++;
      $display("FAIL %s: got out=%03h zncv_fe_err=%07b, expected out=%03h zncv_fe_err=%07b",
               nm, acc_out, got, eo, ef);
    end
  endtask

  initial begin
    acc_reset = 1'b1; acc_wr = 1'b0; acc_op = LD; acc_in = '0;

    // flags field: {z, n, c, v, full, empty, err}
    add(1, 1, LD,  11'h032, 11'h000, 7'b1000_010, "reset_beats_load");
    add(0, 1, LD,  11'h032, 11'h032, 7'b0000_010, "load_032");
    add(0, 1, ADD, 11'h032, 11'h064, 7'b0000_010, "add_032");
    add(0, 1, LD,  11'h3E8, 11'h3E8, 7'b0000_010, "load_3e8");
`ifdef ACC_SATURATE_EN
    add(0, 1, ADD, 11'h064, 11'h3FF, 7'b0001_010, "add_ovf_sat_max");
`else
    add(0, 1, ADD, 11'h064, 11'h44C, 7'b0101_010, "add_ovf_wrap");
`endif
    add(0, 1, LD,  11'h005, 11'h005, 7'b0000_010, "load_005_clears_v");
    add(0, 1, SUB, 11'h007, 11'h7FE, 7'b0110_010, "sub_borrow");
    add(0, 1, XOR, 11'h7FE, 11'h000, 7'b1000_010, "xor_to_zero");
    add(0, 1, LD,  11'h400, 11'h400, 7'b0100_010, "load_min");
`ifdef ACC_SATURATE_EN
    add(0, 1, SUB, 11'h001, 11'h400, 7'b0101_010, "sub_ovf_sat_min");
`else
    add(0, 1, SUB, 11'h001, 11'h3FF, 7'b0001_010, "sub_ovf_wrap");
`endif
    add(0, 1, LD,  11'h7FF, 11'h7FF, 7'b0100_010, "load_7ff");
    add(0, 1, ADD, 11'h001, 11'h000, 7'b1010_010, "add_carry_out");
    add(0, 1, OR,  11'h5A5, 11'h5A5, 7'b0100_010, "or_clears_c");
    add(0, 1, AND, 11'h0F0, 11'h0A0, 7'b0000_010, "and_0f0");
    add(0, 1, XOR, 11'h0FF, 11'h05F, 7'b0000_010, "xor_0ff");
    add(0, 0, LD,  11'h123, 11'h05F, 7'b0000_010, "idle_in_ignored");
    add(0, 0, POP, 11'h7FF, 11'h05F, 7'b0000_010, "idle_op_ignored");
    // stack overflow and LIFO order
    add(1, 0, LD,  11'h000, 11'h000, 7'b1000_010, "reset_stack");
    add(0, 1, LD,  11'h001, 11'h001, 7'b0000_010, "load_1");
    add(0, 1, PSH, 11'h000, 11'h001, 7'b0000_000, "push_1");
    add(0, 1, LD,  11'h002, 11'h002, 7'b0000_000, "load_2");
    add(0, 1, PSH, 11'h000, 11'h002, 7'b0000_000, "push_2");
    add(0, 1, LD,  11'h003, 11'h003, 7'b0000_000, "load_3");
    add(0, 1, PSH, 11'h000, 11'h003, 7'b0000_000, "push_3");
    add(0, 1, LD,  11'h004, 11'h004, 7'b0000_000, "load_4");
    add(0, 1, PSH, 11'h000, 11'h004, 7'b0000_100, "push_4_full");
    add(0, 1, LD,  11'h009, 11'h009, 7'b0000_100, "load_9");
    add(0, 1, PSH, 11'h000, 11'h009, 7'b0000_101, "push_overflow_err");
    add(0, 1, POP, 11'h000, 11'h004, 7'b0000_001, "pop_4");
    add(0, 1, POP, 11'h000, 11'h003, 7'b0000_001, "pop_3");
    add(0, 1, POP, 11'h000, 11'h002, 7'b0000_001, "pop_2");
    add(0, 1, POP, 11'h000, 11'h001, 7'b0000_011, "pop_1_empty");
    // underflow and sticky error
    add(1, 0, LD,  11'h000, 11'h000, 7'b1000_010, "reset_underflow");
    add(0, 1, LD,  11'h0B2, 11'h0B2, 7'b0000_010, "load_0b2");
    add(0, 1, POP, 11'h000, 11'h0B2, 7'b0000_011, "pop_empty_err");
    add(0, 1, ADD, 11'h001, 11'h0B3, 7'b0000_011, "err_sticky_add");
    add(0, 1, LD,  11'h000, 11'h000, 7'b1000_011, "err_sticky_load");
    add(1, 0, LD,  11'h000, 11'h000, 7'b1000_010, "reset_clears_err");

    for (int i = 0; i < vecs.size(); i++)
      step(vecs[i].rst, vecs[i].wr, vecs[i].op, vecs[i].din,
           vecs[i].e_out, vecs[i].e_flags, vecs[i].name);

    // PUSH keeps flags; POP clears C/V and reloads Z/N from the stacked value
    step(0, 1, LD,  11'h7FF, 11'h7FF, 7'b0100_010, "seq_load_7ff");
    step(0, 1, PSH, 11'h000, 11'h7FF, 7'b0100_000, "seq_push_7ff");
    step(0, 1, ADD, 11'h001, 11'h000, 7'b1010_000, "seq_add_sets_c");
    step(0, 1, PSH, 11'h000, 11'h000, 7'b1010_000, "seq_push_keeps_flags");
    step(0, 1, POP, 11'h000, 11'h000, 7'b1000_000, "seq_pop_0_clears_c");
    step(0, 1, POP, 11'h000, 11'h7FF, 7'b0100_010, "seq_pop_7ff");

    // reset mid-sequence discards saved entries
    step(0, 1, LD,  11'h005, 11'h005, 7'b0000_010, "seq_load_5");
    step(0, 1, PSH, 11'h000, 11'h005, 7'b0000_000, "seq_push_5");
    step(1, 1, PSH, 11'h000, 11'h000, 7'b1000_010, "seq_reset_drops_stack");
    step(0, 1, POP, 11'h000, 11'h000, 7'b1000_011, "seq_pop_after_reset_err");

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
